// File: rtl/i2c_slave.sv
// I2C target endpoint: START/STOP detection, 7-bit address match, write bytes out on a
// byte stream, read bytes from a byte source with SCLK stretching and a stretch timeout.
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR    = 7'h42,
  parameter logic [7:0] STRETCH_LIMIT = 8'hBF
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       i2c_sclk_i,
  input  logic       i2c_sdat_i,
  output logic       i2c_sclk_o,
  output logic       i2c_sdat_o,
  output logic       start_o,
  output logic       rw_o,
  output logic       data_valid_o,
  output logic [7:0] data_o,
  input  logic       rx_ready_i,
  output logic       data_read_o,
  input  logic [7:0] data_i,
  input  logic       data_available_i,
  output logic       stop_o,
  output logic       busy_o,
  output logic       error_o
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, LOAD, RD_DATA, RD_ACK
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  sclkSync_q, sdatSync_q;
  logic        sclkPrev_q, sdatPrev_q;
  logic [2:0]  bitCnt_q, bitCnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic [7:0]  stretch_q, stretch_d;
  logic        sdatOut_q, sdatOut_d;
  logic        sclkOut_q, sclkOut_d;
  logic        rw_q, rw_d;
  logic        busy_q, busy_d;
  logic        error_q, error_d;
  logic        phase_q, phase_d;
  logic        nack_q, nack_d;
  logic        start_q, start_d;
  logic        dataValid_q, dataValid_d;
  logic        dataRead_q, dataRead_d;
  logic        stop_q, stop_d;
  logic        doLoad;

  logic sclkLvl, sdatLvl, sclkRise, sclkFall, startCond, stopCond;

  assign sclkLvl   = sclkSync_q[1];
  assign sdatLvl   = sdatSync_q[1];
  assign sclkRise  = sclkLvl & ~sclkPrev_q;
  assign sclkFall  = ~sclkLvl & sclkPrev_q;
  assign startCond = sclkLvl & sclkPrev_q & sdatPrev_q & ~sdatLvl;
  assign stopCond  = sclkLvl & sclkPrev_q & ~sdatPrev_q & sdatLvl;

  // Two-flop synchronizer plus one history flop per line for edge detection.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      sclkSync_q <= 2'b11;
      sdatSync_q <= 2'b11;
      sclkPrev_q <= 1'b1;
      sdatPrev_q <= 1'b1;
    end else begin
      sclkSync_q <= {sclkSync_q[0], i2c_sclk_i};
      sdatSync_q <= {sdatSync_q[0], i2c_sdat_i};
      sclkPrev_q <= sclkSync_q[1];
      sdatPrev_q <= sdatSync_q[1];
    end
  end

  always_comb begin
    state_d     = state_q;
    bitCnt_d    = bitCnt_q;
    shift_d     = shift_q;
    data_d      = data_q;
    stretch_d   = stretch_q;
    sdatOut_d   = sdatOut_q;
    sclkOut_d   = sclkOut_q;
    rw_d        = rw_q;
    busy_d      = busy_q;
    error_d     = error_q;
    phase_d     = phase_q;
    nack_d      = nack_q;
    start_d     = 1'b0;
    dataValid_d = 1'b0;
    dataRead_d  = 1'b0;
    stop_d      = 1'b0;
    doLoad      = 1'b0;

    if (startCond) begin
      state_d   = ADDR;
      bitCnt_d  = 3'd7;
      sdatOut_d = 1'b1;
      sclkOut_d = 1'b1;
      busy_d    = 1'b0;
      error_d   = 1'b0;
      phase_d   = 1'b0;
    end else if (stopCond) begin
      state_d   = IDLE;
      sdatOut_d = 1'b1;
      sclkOut_d = 1'b1;
      stop_d    = busy_q;
      busy_d    = 1'b0;
    end else begin
      unique case (state_q)
        ADDR: begin
          if (sclkRise) begin
            shift_d  = {shift_q[6:0], sdatLvl};
            bitCnt_d = bitCnt_q - 3'd1;
            // The first seven bits are the address, the incoming eighth bit is R/W.
            if (bitCnt_q == 3'd0) begin
              if (shift_q[6:0] == SLAVE_ADDR) begin
                rw_d    = sdatLvl;
                phase_d = 1'b0;
                state_d = ADDR_ACK;
              end else begin
                state_d = IDLE;
              end
            end
          end
        end
        ADDR_ACK: begin
          if (sclkFall) begin
            if (!phase_q) begin
              sdatOut_d = 1'b0;
              busy_d    = 1'b1;
              start_d   = 1'b1;
              phase_d   = 1'b1;
            end else begin
              sdatOut_d = 1'b1;
              if (rw_q) begin
                doLoad = 1'b1;
              end else begin
                bitCnt_d = 3'd7;
                state_d  = WR_DATA;
              end
            end
          end
        end
        WR_DATA: begin
          if (sclkRise) begin
            shift_d  = {shift_q[6:0], sdatLvl};
            bitCnt_d = bitCnt_q - 3'd1;
            if (bitCnt_q == 3'd0) begin
              data_d      = {shift_q[6:0], sdatLvl};
              dataValid_d = 1'b1;
              phase_d     = 1'b0;
              state_d     = WR_ACK;
            end
          end
        end
        WR_ACK: begin
          if (sclkFall) begin
            if (!phase_q) begin
              sdatOut_d = ~rx_ready_i;
              phase_d   = 1'b1;
            end else begin
              sdatOut_d = 1'b1;
              bitCnt_d  = 3'd7;
              state_d   = WR_DATA;
            end
          end
        end
        LOAD: begin
          if (data_available_i) begin
            doLoad = 1'b1;
          end else if (stretch_q == STRETCH_LIMIT) begin
            // Give up waiting: free the clock and shift out all ones.
            error_d   = 1'b1;
            sclkOut_d = 1'b1;
            shift_d   = 8'hFF;
            sdatOut_d = 1'b1;
            bitCnt_d  = 3'd7;
            state_d   = RD_DATA;
          end else begin
            stretch_d = stretch_q + 8'd1;
          end
        end
        RD_DATA: begin
          if (sclkFall) begin
            if (bitCnt_q != 3'd0) begin
              shift_d   = {shift_q[6:0], 1'b1};
              sdatOut_d = shift_q[6];
              bitCnt_d  = bitCnt_q - 3'd1;
            end else begin
              sdatOut_d = 1'b1;
              phase_d   = 1'b0;
              state_d   = RD_ACK;
            end
          end
        end
        RD_ACK: begin
          if (sclkRise) begin
            nack_d  = sdatLvl;
            phase_d = 1'b1;
          end else if (sclkFall && phase_q) begin
            if (!nack_q) begin
              doLoad = 1'b1;
            end else begin
              busy_d  = 1'b0;
              state_d = IDLE;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase

      // Fetch the next read byte now, or start stretching SCLK until it arrives.
      if (doLoad) begin
        if (data_available_i) begin
          shift_d    = data_i;
          sdatOut_d  = data_i[7];
          sclkOut_d  = 1'b1;
          dataRead_d = 1'b1;
          bitCnt_d   = 3'd7;
          state_d    = RD_DATA;
        end else begin
          sdatOut_d = 1'b1;
          sclkOut_d = 1'b0;
          stretch_d = 8'd0;
          state_d   = LOAD;
        end
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      bitCnt_q    <= 3'd7;
      shift_q     <= 8'h00;
      data_q      <= 8'h00;
      stretch_q   <= 8'h00;
      sdatOut_q   <= 1'b1;
      sclkOut_q   <= 1'b1;
      rw_q        <= 1'b0;
      busy_q      <= 1'b0;
      error_q     <= 1'b0;
      phase_q     <= 1'b0;
      nack_q      <= 1'b1;
      start_q     <= 1'b0;
      dataValid_q <= 1'b0;
      dataRead_q  <= 1'b0;
      stop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bitCnt_q    <= bitCnt_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      stretch_q   <= stretch_d;
      sdatOut_q   <= sdatOut_d;
      sclkOut_q   <= sclkOut_d;
      rw_q        <= rw_d;
      busy_q      <= busy_d;
      error_q     <= error_d;
      phase_q     <= phase_d;
      nack_q      <= nack_d;
      start_q     <= start_d;
      dataValid_q <= dataValid_d;
      dataRead_q  <= dataRead_d;
      stop_q      <= stop_d;
    end
  end

  assign i2c_sclk_o   = sclkOut_q;
  assign i2c_sdat_o   = sdatOut_q;
  assign start_o      = start_q;
  assign rw_o         = rw_q;
  assign data_valid_o = dataValid_q;
  assign data_o       = data_q;
  assign data_read_o  = dataRead_q;
  assign stop_o       = stop_q;
  assign busy_o       = busy_q;
  assign error_o      = error_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: a bit-level I2C master model on a wired-AND bus, a byte source,
// and scoreboard queues for written and read bytes.
`timescale 1ns/1ps
module tb_i2c_slave;

  localparam int Q          = 8;
  localparam int WAIT_LIMIT = 2000;
  localparam int NV         = 6;

  logic       clock = 1'b0;
  logic       reset;
  logic       masterScl, masterSda;
  logic       sclLine, sdaLine;
  logic       sclkOut, sdatOut, startPulse, rwOut, dataValid, dataRead, stopPulse, busy, errorOut;
  logic [7:0] dataOut, dataIn;
  logic       rxReady, dataAvailable;

  always #5 clock = ~clock;

  assign sclLine = masterScl & sclkOut;
  assign sdaLine = masterSda & sdatOut;

  i2c_slave dut (
    .clock_i          (clock),
    .reset_i          (reset),
    .i2c_sclk_i       (sclLine),
    .i2c_sdat_i       (sdaLine),
    .i2c_sclk_o       (sclkOut),
    .i2c_sdat_o       (sdatOut),
    .start_o          (startPulse),
    .rw_o             (rwOut),
    .data_valid_o     (dataValid),
    .data_o           (dataOut),
    .rx_ready_i       (rxReady),
    .data_read_o      (dataRead),
    .data_i           (dataIn),
    .data_available_i (dataAvailable),
    .stop_o           (stopPulse),
    .busy_o           (busy),
    .error_o          (errorOut)
  );

  typedef struct {
    logic [7:0] addrByte;
    logic [7:0] byte0;
    logic [7:0] byte1;
    logic       rxReady;
    logic       expAddrAck;
    int         expStarts;
    int         expStops;
    int         expReads;
  } vec_t;

  vec_t       vecs[NV];
  logic [7:0] expWrQ[$];
  logic [7:0] expRdQ[$];
  logic [7:0] srcQ[$];
  logic       srcEn;
  int         errors = 0;
  int         checks = 0;
  int         startCnt, stopCnt, readCnt, sdaLowCnt, dutSclLowCnt, sclLowRun, sclLowMax;
  logic       busySeen, rwAtStart;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic waitSclHigh();
    int n;
    n = 0;
    while (sclLine !== 1'b1 && n < WAIT_LIMIT) begin
      @(negedge clock);
      n++;
    end
    if (n >= WAIT_LIMIT) begin
      checks++;
      errors++;
      $display("[TB] FAIL sclk_release: SCLK still low after %0d cycles, expected released", n);
    end
  endtask

  task automatic sendBit(input logic b, output logic s);
    masterSda = b;
    waitCycles(Q);
    masterScl = 1'b1;
    waitSclHigh();
    waitCycles(Q);
    s = sdaLine;
    waitCycles(Q);
    masterScl = 1'b0;
    waitCycles(Q);
  endtask

  task automatic xferByte(input logic [7:0] tx, output logic [7:0] rx);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      sendBit(tx[i], b);
      rx[i] = b;
    end
  endtask

  task automatic i2cStart();
    masterSda = 1'b1;
    waitCycles(Q);
    masterScl = 1'b1;
    waitSclHigh();
    waitCycles(Q);
    masterSda = 1'b0;
    waitCycles(Q);
    masterScl = 1'b0;
    waitCycles(Q);
  endtask

  task automatic i2cStop();
    masterSda = 1'b0;
    waitCycles(Q);
    masterScl = 1'b1;
    waitSclHigh();
    waitCycles(Q);
    masterSda = 1'b1;
    waitCycles(2 * Q);
  endtask

  task automatic clearMonitors();
    startCnt = 0; stopCnt = 0; readCnt = 0; sdaLowCnt = 0;
    dutSclLowCnt = 0; sclLowRun = 0; sclLowMax = 0; busySeen = 1'b0;
  endtask

  task automatic checkRead(input string name, input logic [7:0] rx);
    if (expRdQ.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected no read byte", name, rx);
    end else begin
      checkOutput(name, rx, expRdQ.pop_front());
    end
  endtask

  // One table record: START, address, two data bytes (write or read), STOP.
  task automatic applyStimulus(input vec_t v);
    logic       ack;
    logic [7:0] rx;
    clearMonitors();
    rxReady = v.rxReady;
    if (v.expAddrAck && v.addrByte[0]) begin
      srcQ.push_back(v.byte0);   srcQ.push_back(v.byte1);
      expRdQ.push_back(v.byte0); expRdQ.push_back(v.byte1);
    end
    i2cStart();
    xferByte(v.addrByte, rx);
    sendBit(1'b1, ack);
    checkOutput("addr_ack", ack, !v.expAddrAck);
    if (v.expAddrAck) begin
      if (!v.addrByte[0]) begin
        expWrQ.push_back(v.byte0);
        xferByte(v.byte0, rx);
        sendBit(1'b1, ack);
        checkOutput("wr0_ack", ack, !v.rxReady);
        expWrQ.push_back(v.byte1);
        xferByte(v.byte1, rx);
        sendBit(1'b1, ack);
        checkOutput("wr1_ack", ack, !v.rxReady);
      end else begin
        xferByte(8'hFF, rx);
        checkRead("rd0", rx);
        sendBit(1'b0, ack);
        xferByte(8'hFF, rx);
        checkRead("rd1", rx);
        sendBit(1'b1, ack);
      end
    end
    i2cStop();
    checkOutput("start_count", startCnt, v.expStarts);
    checkOutput("stop_count", stopCnt, v.expStops);
    checkOutput("read_count", readCnt, v.expReads);
    checkOutput("wr_queue_drained", expWrQ.size(), 0);
    if (v.expAddrAck) begin
      checkOutput("rw", rwAtStart, v.addrByte[0]);
      if (v.addrByte[0]) checkOutput("no_stretch", dutSclLowCnt, 0);
    end else begin
      checkOutput("sda_untouched", sdaLowCnt, 0);
      checkOutput("busy_never", busySeen, 0);
    end
  endtask

  // Bus monitor, scoreboard for write bytes, and byte source model.
  initial begin
    dataIn = 8'h00;
    dataAvailable = 1'b0;
    clearMonitors();
    rwAtStart = 1'b0;
    forever begin
      @(negedge clock);
      if (startPulse) begin
        startCnt++;
        rwAtStart = rwOut;
      end
      if (stopPulse) stopCnt++;
      if (dataValid) begin
        if (expWrQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL data_valid: got pulse with data_o=0x%0h, expected none", dataOut);
        end else begin
          checkOutput("data_o", dataOut, expWrQ.pop_front());
        end
      end
      if (dataRead) begin
        readCnt++;
        if (srcQ.size() > 0) void'(srcQ.pop_front());
      end
      if (!sdatOut) sdaLowCnt++;
      if (busy) busySeen = 1'b1;
      if (!sclkOut) dutSclLowCnt++;
      if (!sclLine) begin
        sclLowRun++;
        if (sclLowRun > sclLowMax) sclLowMax = sclLowRun;
      end else begin
        sclLowRun = 0;
      end
      dataAvailable = srcEn && (srcQ.size() > 0);
      dataIn = (srcQ.size() > 0) ? srcQ[0] : 8'h00;
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic       ack;
    logic [7:0] rx;
    logic [7:0] partial;

    vecs[0] = '{8'h84, 8'h5A, 8'hC3, 1'b1, 1'b1, 1, 1, 0};
    vecs[1] = '{8'h86, 8'h00, 8'h00, 1'b1, 1'b0, 0, 0, 0};
    vecs[2] = '{8'h85, 8'hA5, 8'h3C, 1'b1, 1'b1, 1, 0, 2};
    vecs[3] = '{8'h00, 8'h11, 8'h22, 1'b1, 1'b0, 0, 0, 0};
    vecs[4] = '{8'h84, 8'h00, 8'hFF, 1'b1, 1'b1, 1, 1, 0};
    vecs[5] = '{8'h85, 8'hFF, 8'h00, 1'b1, 1'b1, 1, 0, 2};

    reset = 1'b1; masterScl = 1'b1; masterSda = 1'b1; rxReady = 1'b1; srcEn = 1'b1;
    waitCycles(5);
    checkOutput("rst_sclk", sclkOut, 1);
    checkOutput("rst_sdat", sdatOut, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_error", errorOut, 0);
    checkOutput("rst_data", dataOut, 0);
    checkOutput("rst_start", startPulse, 0);
    checkOutput("rst_dvalid", dataValid, 0);
    reset = 1'b0;
    waitCycles(5);

    for (int i = 0; i < NV; i++) applyStimulus(vecs[i]);

    // Stretch: read data shows up 22 cycles after the ACK clock falls.
    clearMonitors();
    srcEn = 1'b0;
    srcQ.push_back(8'h77);
    expRdQ.push_back(8'h77);
    i2cStart();
    xferByte(8'h85, rx);
    sendBit(1'b1, ack);
    checkOutput("stretch_addr_ack", ack, 0);
    fork
      begin
        waitCycles(14);
        srcEn = 1'b1;
      end
    join_none
    xferByte(8'hFF, rx);
    checkRead("stretch_byte", rx);
    sendBit(1'b1, ack);
    i2cStop();
    checkOutput("stretch_len_ge_20", sclLowMax >= 20, 1);
    checkOutput("stretch_reads", readCnt, 1);
    checkOutput("stretch_no_error", errorOut, 0);

    // Timeout: the source never supplies data.
    clearMonitors();
    srcEn = 1'b0;
    expRdQ.push_back(8'hFF);
    i2cStart();
    xferByte(8'h85, rx);
    sendBit(1'b1, ack);
    checkOutput("timeout_addr_ack", ack, 0);
    xferByte(8'hFF, rx);
    checkRead("timeout_byte", rx);
    checkOutput("timeout_error", errorOut, 1);
    checkOutput("timeout_no_read", readCnt, 0);
    checkOutput("timeout_held", dutSclLowCnt >= 190, 1);
    sendBit(1'b1, ack);
    i2cStop();
    checkOutput("error_sticky", errorOut, 1);
    srcEn = 1'b1;
    i2cStart();
    checkOutput("error_cleared", errorOut, 0);
    xferByte(8'h84, rx);
    sendBit(1'b1, ack);
    checkOutput("after_timeout_ack", ack, 0);
    i2cStop();

    // Repeated START in the middle of a write byte, then a NACKed byte.
    clearMonitors();
    rxReady = 1'b1;
    partial = 8'hF0;
    i2cStart();
    xferByte(8'h84, rx);
    sendBit(1'b1, ack);
    checkOutput("rs_addr1_ack", ack, 0);
    for (int i = 7; i >= 4; i--) sendBit(partial[i], ack);
    i2cStart();
    xferByte(8'h84, rx);
    sendBit(1'b1, ack);
    checkOutput("rs_addr2_ack", ack, 0);
    checkOutput("rs_starts", startCnt, 2);
    rxReady = 1'b0;
    expWrQ.push_back(8'h99);
    xferByte(8'h99, rx);
    sendBit(1'b1, ack);
    checkOutput("rs_nack", ack, 1);
    i2cStop();
    checkOutput("rs_stops", stopCnt, 1);
    checkOutput("rs_queue_drained", expWrQ.size(), 0);

    // Reset while the target is stretching a read.
    clearMonitors();
    rxReady = 1'b1;
    srcEn = 1'b0;
    i2cStart();
    xferByte(8'h85, rx);
    sendBit(1'b1, ack);
    waitCycles(4);
    checkOutput("pre_reset_stretch", sclkOut, 0);
    checkOutput("pre_reset_busy", busy, 1);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("reset_sclk", sclkOut, 1);
    checkOutput("reset_sdat", sdatOut, 1);
    checkOutput("reset_busy", busy, 0);
    reset = 1'b0;
    srcEn = 1'b1;
    i2cStop();
    checkOutput("reset_no_stop", stopCnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
